// File: rtl/vga_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync/de,
// checks line and frame geometry, and captures the colour at one probe point.
//
// state  | meaning
// -------+---------------------------------------------------------------
// SEARCH | waiting for the first vsync fall; nothing is checked
// ALIGN  | observing a whole frame; any mismatch only marks the frame bad
// LOCKED | geometry verified; mismatches set err, bump err_cnt, drop lock
module vga_rx #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    input  logic [5:0] rgb,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    input  logic       err_clr,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de_o,
    output logic       locked,
    output logic [3:0] err,
    output logic [7:0] err_cnt,
    output logic [7:0] frame_cnt,
    output logic [5:0] probe_rgb,
    output logic       probe_valid
);

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOT = 10'(H_TOTAL);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT = 10'(V_TOTAL);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_n;

    logic       hs_r, hs_d, vs_r, vs_d, de_r, de_d;
    logic [5:0] rgb_r;
    logic       hs_fall, vs_fall, de_fall;

    logic [9:0] cx, cy, col_a, row_a;
    logic [9:0] hper, delen, lines, alines, alines_tot;
    logic       hvalid;
    logic       h_err, de_err, vt_err, al_err, any_mis;
    logic [3:0] mis;
    logic       probe_hit;

    logic       frame_bad, frame_bad_n;
    logic [3:0] err_n;
    logic [7:0] err_cnt_n, frame_cnt_n;

    function automatic logic [9:0] inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Input capture plus a second stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            de_r  <= 1'b0;
            de_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            hs_r  <= hsync;
            hs_d  <= hs_r;
            vs_r  <= vsync;
            vs_d  <= vs_r;
            de_r  <= de;
            de_d  <= de_r;
            rgb_r <= rgb;
        end
    end

    // Zero reset values on the first stage mean no edge is seen at release.
    assign hs_fall = hs_d & ~hs_r;
    assign vs_fall = vs_d & ~vs_r;
    assign de_fall = de_d & ~de_r;

    // Coordinate given to the pixel currently held in de_r/rgb_r.
    assign col_a = hs_fall ? 10'd0 : cx;
    assign row_a = vs_fall ? 10'd0 : cy;

    // An hs_fall closing a line with de also closes that line's alines count.
    assign alines_tot = (hs_fall && delen != 10'd0) ? inc10(alines) : alines;

    // hvalid suppresses line checks until one full line has been bracketed.
    assign h_err   = hs_fall & hvalid & (hper != H_TOT);
    assign de_err  = hs_fall & hvalid & (delen != 10'd0) & (delen != H_ACT);
    assign vt_err  = vs_fall & (lines != V_TOT);
    assign al_err  = vs_fall & (alines_tot != V_ACT);
    assign mis     = {al_err, de_err, vt_err, h_err};
    assign any_mis = |mis;

    assign probe_hit = (state == LOCKED) & de_r & (col_a == probe_x) & (row_a == probe_y)
                     & (probe_x < H_ACT) & (probe_y < V_ACT);

    // Coordinate and geometry counters; all saturate so overruns are caught.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx     <= '0;
            cy     <= '0;
            hper   <= '0;
            delen  <= '0;
            lines  <= '0;
            alines <= '0;
            hvalid <= 1'b0;
        end else begin
            cx     <= de_r ? inc10(col_a) : col_a;
            cy     <= de_fall ? inc10(row_a) : row_a;
            hper   <= hs_fall ? 10'd1 : inc10(hper);
            delen  <= hs_fall ? {9'd0, de_r} : (de_r ? inc10(delen) : delen);
            hvalid <= hvalid | hs_fall;
            if (vs_fall)
                lines <= {9'd0, hs_fall};
            else if (hs_fall)
                lines <= inc10(lines);
            alines <= vs_fall ? 10'd0 : alines_tot;
        end
    end

    // Pixel outputs and probe capture, one cycle behind the input register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de_o        <= 1'b0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            de_o        <= de_r;
            x           <= de_r ? col_a : (hs_fall ? 10'd0 : x);
            y           <= de_r ? row_a : (vs_fall ? 10'd0 : y);
            probe_valid <= probe_hit;
            if (probe_hit)
                probe_rgb <= rgb_r;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            frame_bad <= 1'b0;
            err       <= '0;
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            frame_bad <= frame_bad_n;
            err       <= err_n;
            err_cnt   <= err_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    // Next state and status; a clear and a new error in one cycle leaves the new error.
    always_comb begin
        state_n     = state;
        err_n       = err_clr ? 4'd0 : err;
        err_cnt_n   = err_clr ? 8'd0 : err_cnt;
        frame_cnt_n = frame_cnt;
        frame_bad_n = vs_fall ? 1'b0 : (frame_bad | any_mis);
        case (state)
            SEARCH: begin
                frame_bad_n = 1'b0;
                if (vs_fall)
                    state_n = ALIGN;
            end
            ALIGN: begin
                if (vs_fall && !(frame_bad || any_mis))
                    state_n = LOCKED;
            end
            LOCKED: begin
                if (any_mis) begin
                    state_n = ALIGN;
                    err_n   = err_n | mis;
                    if (err_cnt_n != 8'hFF)
                        err_cnt_n = err_cnt_n + 8'd1;
                end else if (vs_fall) begin
                    frame_cnt_n = frame_cnt + 8'd1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx using a reduced 8x4 (14x7 total) raster.
module tb_vga_rx;

    localparam int HA = 8;
    localparam int HT = 14;
    localparam int VA = 4;
    localparam int VT = 7;
    localparam int PX = 5;
    localparam int PY = 2;
    localparam logic [5:0] SPRITE = 6'b000100;
    localparam logic [5:0] BG     = 6'b111000;

    logic       clk = 1'b0;
    logic       rst_n, hsync, vsync, de, err_clr;
    logic [5:0] rgb;
    logic [9:0] probe_x, probe_y;
    logic [9:0] x, y;
    logic       de_o, locked, probe_valid;
    logic [3:0] err;
    logic [7:0] err_cnt, frame_cnt;
    logic [5:0] probe_rgb;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    bit chk_xy = 1'b1;
    bit clr_pend = 1'b0;
    bit clr_chk = 1'b0;
    logic pde0, pde1;
    int px0, px1, py0, py1;

    vga_rx #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
        .x(x), .y(y), .de_o(de_o), .locked(locked), .err(err), .err_cnt(err_cnt),
        .frame_cnt(frame_cnt), .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check the pixel driven two steps ago, then drive the next one.
    task automatic step(input logic hs_i, input logic vs_i, input logic de_i,
                        input logic [5:0] rgb_i, input int col, input int row);
        @(negedge clk);
        chk("de_o", 32'(de_o), 32'(pde1));
        if (chk_xy && pde1) begin
            chk("x", 32'(x), 32'(px1));
            chk("y", 32'(y), 32'(py1));
        end
        if (probe_valid) begin
            pv_cnt++;
            chk("probe_x_align", 32'(x), 32'(PX));
            chk("probe_y_align", 32'(y), 32'(PY));
        end
        if (clr_chk) begin
            chk("clr_err", 32'(err), 32'd0);
            chk("clr_cnt", 32'(err_cnt), 32'd0);
            clr_chk = 1'b0;
        end
        err_clr = 1'b0;
        if (clr_pend) begin
            err_clr  = 1'b1;
            clr_pend = 1'b0;
            clr_chk  = 1'b1;
        end
        pde1 = pde0; px1 = px0; py1 = py0;
        pde0 = de_i; px0 = col; py0 = row;
        hsync = hs_i;
        vsync = vs_i;
        de    = de_i;
        rgb   = rgb_i;
    endtask

    // One frame from its top line; -1 disables each optional disturbance.
    task automatic drive_frame(input int stop_l, input int stretch_l, input int drop_l,
                               input int drop_c, input int skip_l);
        pv_cnt = 0;
        for (int l = 0; l < VT; l++) begin
            if (l == skip_l) continue;
            for (int c = 0; c < ((l == stretch_l) ? HT + 1 : HT); c++) begin
                logic de_i;
                logic [5:0] rgb_i;
                de_i  = (l < VA) && (c < HA) && !(l == drop_l && c == drop_c);
                rgb_i = !de_i ? 6'd0 : ((c == PX && l == PY) ? SPRITE : BG);
                step(!(c >= HA + 2 && c < HA + 4), (l != 5), de_i, rgb_i, c, l);
                if (l == stop_l && c == 7) return;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_de_o"}, 32'(de_o), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_probe_rgb"}, 32'(probe_rgb), 32'd0);
        chk({tag, "_probe_valid"}, 32'(probe_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b0; rgb = '0; err_clr = 1'b0;
        probe_x = 10'(PX); probe_y = 10'(PY);
        pde0 = 1'b0; pde1 = 1'b0; px0 = 0; px1 = 0; py0 = 0; py1 = 0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // F0: first vsync fall after reset moves to ALIGN only.
        drive_frame(-1, -1, -1, -1, -1);
        chk("f0_locked", 32'(locked), 32'd0);
        chk("f0_probe_cnt", 32'(pv_cnt), 32'd0);

        // F1: one clean frame observed, lock at its vsync fall.
        drive_frame(-1, -1, -1, -1, -1);
        chk("f1_locked", 32'(locked), 32'd1);
        chk("f1_err", 32'(err), 32'd0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("f1_probe_cnt", 32'(pv_cnt), 32'd0);

        // F2/F3: locked frames count and capture the sprite once each.
        drive_frame(-1, -1, -1, -1, -1);
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f2_probe_cnt", 32'(pv_cnt), 32'd1);
        chk("f2_probe_rgb", 32'(probe_rgb), 32'(SPRITE));
        drive_frame(-1, -1, -1, -1, -1);
        chk("f3_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f3_probe_cnt", 32'(pv_cnt), 32'd1);

        // F4: line 1 stretched to HT+1 clocks.
        drive_frame(-1, 1, -1, -1, -1);
        chk("f4_err", 32'(err), 32'h1);
        chk("f4_err_cnt", 32'(err_cnt), 32'd1);
        chk("f4_locked", 32'(locked), 32'd0);

        // F5: clean frame relocks; errors are sticky.
        drive_frame(-1, -1, -1, -1, -1);
        chk("f5_locked", 32'(locked), 32'd1);
        chk("f5_err", 32'(err), 32'h1);
        chk("f5_frame_cnt", 32'(frame_cnt), 32'd2);

        // F6: one de clock dropped in line 1.
        chk_xy = 1'b0;
        drive_frame(-1, -1, 1, 3, -1);
        chk_xy = 1'b1;
        chk("f6_err", 32'(err), 32'h5);
        chk("f6_err_cnt", 32'(err_cnt), 32'd2);
        chk("f6_locked", 32'(locked), 32'd0);

        drive_frame(-1, -1, -1, -1, -1);
        chk("f7_locked", 32'(locked), 32'd1);
        chk("f7_frame_cnt", 32'(frame_cnt), 32'd2);

        // F8: one blank line missing, so VT-1 lines between vsync falls.
        drive_frame(-1, -1, -1, -1, 4);
        chk("f8_err", 32'(err), 32'h7);
        chk("f8_err_cnt", 32'(err_cnt), 32'd3);
        chk("f8_locked", 32'(locked), 32'd0);

        drive_frame(-1, -1, -1, -1, -1);
        chk("f9_locked", 32'(locked), 32'd1);
        chk("f9_err", 32'(err), 32'h7);

        // F10: clear while locked, then stop mid-line in line 2.
        clr_pend = 1'b1;
        drive_frame(2, -1, -1, -1, -1);
        chk("f10_locked", 32'(locked), 32'd1);
        chk("f10_err", 32'(err), 32'd0);
        chk("f10_err_cnt", 32'(err_cnt), 32'd0);
        chk("f10_probe_cnt", 32'(pv_cnt), 32'd1);
        chk("f10_de_o", 32'(de_o), 32'd1);

        // Asynchronous reset mid-frame.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        hsync = 1'b1; vsync = 1'b1; de = 1'b0; rgb = '0;
        pde0 = 1'b0; pde1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        drive_frame(-1, -1, -1, -1, -1);
        chk("f11_locked", 32'(locked), 32'd0);
        drive_frame(-1, -1, -1, -1, -1);
        chk("f12_locked", 32'(locked), 32'd1);
        chk("f12_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("f12_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
